core2axi_mo: RTL and testbench
==============================

Name: core2axi_mo

Overview:
- Multiple-outstanding successor of the single-transaction core-to-AXI4 bridge.
- Converts the core's req/gnt/rvalid data port into single-beat AXI4 transactions.
- Keeps up to MAX_OUTSTANDING transactions in flight and returns responses to the core in issue order.
- Supports 32/64/128-bit AXI data buses. Sits between the core LSU and the SoC AXI crossbar.

Parameters:
- AXI4_ADDRESS_WIDTH, 32, address width.
- AXI4_DATA_WIDTH, 64, AXI read and write data width; legal values 32, 64, 128.
- AXI4_ID_WIDTH, 16, ID width; all IDs driven to 0.
- AXI4_USER_WIDTH, 10, user width; all user outputs driven to 0.
- MAX_OUTSTANDING, 4, maximum granted-but-unanswered transactions; legal range 1..16.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- data_req_i  input  1  core request
- data_gnt_o  output  1  request accepted
- data_rvalid_o  output  1  response valid, in request order
- data_addr_i  input  AXI4_ADDRESS_WIDTH  byte address
- data_we_i  input  1  1 = write
- data_be_i  input  4  byte enables
- data_wdata_i  input  32  write data
- data_rdata_o  output  32  read data
- aw_valid_o / aw_ready_i / aw_addr_o  out/in/out  1/1/AXI4_ADDRESS_WIDTH  write address channel
- w_valid_o / w_ready_i / w_data_o / w_strb_o  out/in/out/out  1/1/AXI4_DATA_WIDTH/AXI4_DATA_WIDTH/8  write data channel
- b_valid_i / b_ready_o / b_resp_i  in/out/in  1/1/2  write response channel
- ar_valid_o / ar_ready_i / ar_addr_o  out/in/out  1/1/AXI4_ADDRESS_WIDTH  read address channel
- r_valid_i / r_ready_o / r_data_i / r_resp_i / r_last_i  in/out/in/in/in  1/1/AXI4_DATA_WIDTH/2/1  read data channel
- remaining AXI4 sideband signals (aw/ar id, len, size, burst, lock, cache, prot, region, qos, user; w_last, w_user; b/r id and user inputs)  standard widths  tied constants or ignored

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous, active-low, rst_ni.
- Reset values: all *_valid_o, *_ready_o, data_gnt_o and data_rvalid_o are 0; tracking FIFO empty; aw_done_q = 0, w_done_q = 0; data_rdata_o = 0 if registered, else combinational.
- Constant outputs:
  - len = 0, size = 3'b010, burst = 0, w_last_o = 1; all other sideband outputs 0.
  - aw_addr_o and ar_addr_o = data_addr_i.
- Tracking FIFO: depth MAX_OUTSTANDING; each entry is {is_write, word offset = addr[log2(AXI4_DATA_WIDTH/8)-1:2]}.
- Issue gating: a new request may start only when
  - the FIFO is not full, and
  - the FIFO is empty or its tail entry type equals data_we_i (no read/write mixing in flight; this guarantees ordering).
  - If gated, no AXI valid is asserted and data_gnt_o stays 0.
- Read issue:
  - ar_valid_o = data_req_i & issue_ok.
  - On ar_valid_o & ar_ready_i: data_gnt_o = 1 in the same cycle (combinational) and push {0, offset}.
- Write issue:
  - aw_valid_o = req & ok & ~aw_done_q; w_valid_o = req & ok & ~w_done_q.
  - Each handshake sets its done flag, unless the other channel's handshake is also completing in the same cycle.
  - data_gnt_o = 1 in the cycle the second handshake completes (or both complete together); push {1, offset}; clear both flags.
- Core protocol requirement: the core holds addr, we, be and wdata stable from req until gnt. Flagged by a simulation assertion.
- Write data lane:
  - data_wdata_i is replicated across all 32-bit lanes.
  - w_strb_o = data_be_i shifted left by 4*offset.
- Response path:
  - b_ready_o = FIFO non-empty & head.is_write.
  - r_ready_o = FIFO non-empty & ~head.is_write.
  - On the matching handshake: data_rvalid_o = 1 in the same cycle and pop the head.
  - data_rdata_o = r_data_i[32*head.offset +: 32] for reads; 0 for writes.
- Simultaneous push and pop: occupancy is unchanged. A pop and a push in the same cycle when the FIFO is full is legal, but issue_ok uses the registered full flag, so there is no same-cycle bypass.
- Error responses and r_last_i do not alter control flow.
- Reset mid-operation: the FIFO and done flags clear. Outstanding AXI responses arriving after reset are the system's responsibility.

Optional Feature:
- Macro: CORE2AXI_MO_ERR_EN.
- Defined: adds port data_err_o (output, 1 bit) = data_rvalid_o & (selected resp != 2'b00), where the selected resp is b_resp_i or r_resp_i according to the head entry type. Reset value 0.
- Not defined: the port is absent and the resp inputs are ignored.

Decomposition:
- Package core2axi_pkg holds:
  - the resp localparams OKAY, EXOKAY, SLVERR, DECERR;
  - the tracking-entry struct type;
  - the function computing offset width from AXI4_DATA_WIDTH.
- One sub-module: core2axi_track_fifo, a parametrised sync FIFO with full/empty flags and head/tail visibility.

Test Plan:
- Read, ready always high, MAX_OUTSTANDING = 4: 4 back-to-back reads at 0x100/0x104/0x108/0x10C -> 4 grants in 4 cycles. A 5th read is stalled with ar_valid_o = 0 until the first R handshake. Returned rdata takes 64-bit lanes 0,1,0,1.
- Write, aw_ready delayed 3 cycles and w_ready immediate -> w handshake in cycle 0, aw in cycle 3, data_gnt_o in cycle 3. Write at 0x4 with be = 4'b0011 gives w_strb_o = 8'h30 on a 64-bit bus.
- Type switch: read outstanding, then write request -> aw_valid_o and w_valid_o stay 0 until the R response pops the FIFO; the write is then granted.
- Push and pop in the same cycle (R handshake while a new AR is accepted) -> occupancy unchanged; rvalid and gnt both 1.
- Reset asserted with 2 reads outstanding -> all outputs 0 within the same cycle; the first request after reset is accepted normally.
- CORE2AXI_MO_ERR_EN: b_resp_i = 2'b10 -> data_err_o = 1 with data_rvalid_o; OKAY -> data_err_o = 0.

Source files
------------

// File: rtl/core2axi_pkg.sv
// Shared types and helpers for the multiple-outstanding core-to-AXI4 bridge.
package core2axi_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Widest word offset needed (128-bit bus = 4 lanes); narrower buses zero-extend.
    localparam int OFFS_MAX_W = 2;

    typedef struct packed {
        logic                  is_write;
        logic [OFFS_MAX_W-1:0] offset;
    } track_entry_t;

    function automatic int offset_width(input int data_width);
        return $clog2(data_width / 8) - 2;
    endfunction

endpackage

// File: rtl/core2axi_track_fifo.sv
// Small synchronous FIFO tracking in-flight transactions; exposes head and most recent push (tail).
module core2axi_track_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [WIDTH-1:0] tail_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             push_en, pop_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign tail_o  = tail_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        tail_d   = tail_q;
        if (push_en) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            tail_d   = push_data_i;
        end
        if (pop_en) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_en && !pop_en) begin
            count_d = count_q + 1'b1;
        end else if (pop_en && !push_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tail_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tail_q   <= tail_d;
        end
    end

    // Entry storage needs no reset: it is only observed while the count says it is valid.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/core2axi_mo.sv
// Core req/gnt/rvalid port to single-beat AXI4 with up to MAX_OUTSTANDING in flight, in-order responses.
// Optional: define CORE2AXI_MO_ERR_EN to add data_err_o flagging non-OKAY responses.
module core2axi_mo
    import core2axi_pkg::*;
#(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 64,
    parameter int AXI4_ID_WIDTH      = 16,
    parameter int AXI4_USER_WIDTH    = 10,
    parameter int MAX_OUTSTANDING    = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            data_req_i,
    output logic                            data_gnt_o,
    output logic                            data_rvalid_o,
    input  logic [AXI4_ADDRESS_WIDTH-1:0]   data_addr_i,
    input  logic                            data_we_i,
    input  logic [3:0]                      data_be_i,
    input  logic [31:0]                     data_wdata_i,
    output logic [31:0]                     data_rdata_o,
`ifdef CORE2AXI_MO_ERR_EN
    output logic                            data_err_o,
`endif
    output logic                            aw_valid_o,
    input  logic                            aw_ready_i,
    output logic [AXI4_ADDRESS_WIDTH-1:0]   aw_addr_o,
    output logic [AXI4_ID_WIDTH-1:0]        aw_id_o,
    output logic [7:0]                      aw_len_o,
    output logic [2:0]                      aw_size_o,
    output logic [1:0]                      aw_burst_o,
    output logic                            aw_lock_o,
    output logic [3:0]                      aw_cache_o,
    output logic [2:0]                      aw_prot_o,
    output logic [3:0]                      aw_region_o,
    output logic [3:0]                      aw_qos_o,
    output logic [AXI4_USER_WIDTH-1:0]      aw_user_o,
    output logic                            w_valid_o,
    input  logic                            w_ready_i,
    output logic [AXI4_DATA_WIDTH-1:0]      w_data_o,
    output logic [AXI4_DATA_WIDTH/8-1:0]    w_strb_o,
    output logic                            w_last_o,
    output logic [AXI4_USER_WIDTH-1:0]      w_user_o,
    input  logic                            b_valid_i,
    output logic                            b_ready_o,
    input  logic [1:0]                      b_resp_i,
    input  logic [AXI4_ID_WIDTH-1:0]        b_id_i,
    input  logic [AXI4_USER_WIDTH-1:0]      b_user_i,
    output logic                            ar_valid_o,
    input  logic                            ar_ready_i,
    output logic [AXI4_ADDRESS_WIDTH-1:0]   ar_addr_o,
    output logic [AXI4_ID_WIDTH-1:0]        ar_id_o,
    output logic [7:0]                      ar_len_o,
    output logic [2:0]                      ar_size_o,
    output logic [1:0]                      ar_burst_o,
    output logic                            ar_lock_o,
    output logic [3:0]                      ar_cache_o,
    output logic [2:0]                      ar_prot_o,
    output logic [3:0]                      ar_region_o,
    output logic [3:0]                      ar_qos_o,
    output logic [AXI4_USER_WIDTH-1:0]      ar_user_o,
    input  logic                            r_valid_i,
    output logic                            r_ready_o,
    input  logic [AXI4_DATA_WIDTH-1:0]      r_data_i,
    input  logic [1:0]                      r_resp_i,
    input  logic                            r_last_i,
    input  logic [AXI4_ID_WIDTH-1:0]        r_id_i,
    input  logic [AXI4_USER_WIDTH-1:0]      r_user_i
);

    localparam int OFFS_W = offset_width(AXI4_DATA_WIDTH);
    localparam int NLANES = AXI4_DATA_WIDTH / 32;

    track_entry_t          head, tail, push_entry;
    logic                  fifo_full, fifo_empty;
    logic [OFFS_MAX_W-1:0] req_off;
    logic                  issue_ok, rd_go, wr_go, rd_hs, wr_done, pop;
    logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;

    generate
        if (OFFS_W > 0) begin : g_off
            assign req_off = OFFS_MAX_W'(data_addr_i[OFFS_W+1:2]);
        end else begin : g_no_off
            assign req_off = '0;
        end
    endgenerate

    // Only one transaction type may be in flight at a time, which keeps responses ordered.
    assign issue_ok = ~fifo_full & (fifo_empty | (tail.is_write == data_we_i));
    assign rd_go    = data_req_i & issue_ok & ~data_we_i;
    assign wr_go    = data_req_i & issue_ok & data_we_i;

    assign ar_valid_o = rd_go;
    assign aw_valid_o = wr_go & ~aw_done_q;
    assign w_valid_o  = wr_go & ~w_done_q;
    assign rd_hs      = rd_go & ar_ready_i;
    assign wr_done    = wr_go & (aw_done_q | aw_ready_i) & (w_done_q | w_ready_i);
    assign data_gnt_o = rd_hs | wr_done;

    assign push_entry.is_write = data_we_i;
    assign push_entry.offset   = req_off;

    always_comb begin
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        if (wr_done) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else begin
            if (aw_valid_o && aw_ready_i) aw_done_d = 1'b1;
            if (w_valid_o && w_ready_i)   w_done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    core2axi_track_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH ($bits(track_entry_t))
    ) u_track_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (data_gnt_o),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .tail_o      (tail),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign b_ready_o     = ~fifo_empty & head.is_write;
    assign r_ready_o     = ~fifo_empty & ~head.is_write;
    assign pop           = (b_valid_i & b_ready_o) | (r_valid_i & r_ready_o);
    assign data_rvalid_o = pop;

    always_comb begin
        data_rdata_o = '0;
        for (int i = 0; i < NLANES; i++) begin
            if (r_ready_o && head.offset == OFFS_MAX_W'(i)) begin
                data_rdata_o = r_data_i[32*i +: 32];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
            assign w_data_o[32*gi +: 32] = data_wdata_i;
            assign w_strb_o[4*gi +: 4]   = (req_off == OFFS_MAX_W'(gi)) ? data_be_i : 4'b0000;
        end
    endgenerate

`ifdef CORE2AXI_MO_ERR_EN
    assign data_err_o = data_rvalid_o & ((head.is_write ? b_resp_i : r_resp_i) != OKAY);
    logic unused_in;
    assign unused_in = ^{b_id_i, b_user_i, r_id_i, r_user_i, r_last_i, tail.offset};
`else
    logic unused_in;
    assign unused_in = ^{b_id_i, b_user_i, r_id_i, r_user_i, r_last_i, tail.offset, b_resp_i, r_resp_i};
`endif

    assign aw_addr_o   = data_addr_i;
    assign aw_id_o     = '0;
    assign aw_len_o    = 8'd0;
    assign aw_size_o   = 3'b010;
    assign aw_burst_o  = 2'b00;
    assign aw_lock_o   = 1'b0;
    assign aw_cache_o  = 4'd0;
    assign aw_prot_o   = 3'd0;
    assign aw_region_o = 4'd0;
    assign aw_qos_o    = 4'd0;
    assign aw_user_o   = '0;
    assign w_last_o    = 1'b1;
    assign w_user_o    = '0;
    assign ar_addr_o   = data_addr_i;
    assign ar_id_o     = '0;
    assign ar_len_o    = 8'd0;
    assign ar_size_o   = 3'b010;
    assign ar_burst_o  = 2'b00;
    assign ar_lock_o   = 1'b0;
    assign ar_cache_o  = 4'd0;
    assign ar_prot_o   = 3'd0;
    assign ar_region_o = 4'd0;
    assign ar_qos_o    = 4'd0;
    assign ar_user_o   = '0;

`ifndef SYNTHESIS
    // The core must not change a pending request before it is granted.
    req_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (data_req_i && !data_gnt_o) |=> $stable({data_addr_i, data_we_i, data_be_i, data_wdata_i}));
`endif

endmodule

// File: tb/tb_core2axi_mo.sv
// Directed bench for core2axi_mo (64-bit bus, 4 outstanding); data_err_o checks need CORE2AXI_MO_ERR_EN.
module tb_core2axi_mo;
    import core2axi_pkg::*;

    localparam int AW = 32, DW = 64, IDW = 16, UW = 10, MO = 4;

    logic clk_i = 1'b0, rst_ni = 1'b0;
    logic data_req_i = 1'b0, data_we_i = 1'b0;
    logic [AW-1:0] data_addr_i = '0;
    logic [3:0] data_be_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic data_gnt_o, data_rvalid_o;
    logic [31:0] data_rdata_o;
`ifdef CORE2AXI_MO_ERR_EN
    logic data_err_o;
`endif
    logic aw_valid_o, aw_ready_i = 1'b0, aw_lock_o, w_valid_o, w_ready_i = 1'b0, w_last_o;
    logic [AW-1:0] aw_addr_o, ar_addr_o;
    logic [IDW-1:0] aw_id_o, ar_id_o;
    logic [7:0] aw_len_o, ar_len_o;
    logic [2:0] aw_size_o, ar_size_o, aw_prot_o, ar_prot_o;
    logic [1:0] aw_burst_o, ar_burst_o;
    logic [3:0] aw_cache_o, aw_region_o, aw_qos_o, ar_cache_o, ar_region_o, ar_qos_o;
    logic [UW-1:0] aw_user_o, ar_user_o, w_user_o;
    logic [DW-1:0] w_data_o;
    logic [DW/8-1:0] w_strb_o;
    logic b_valid_i = 1'b0, b_ready_o, ar_valid_o, ar_ready_i = 1'b0, ar_lock_o;
    logic [1:0] b_resp_i = 2'b00, r_resp_i = 2'b00;
    logic [IDW-1:0] b_id_i = '0, r_id_i = '0;
    logic [UW-1:0] b_user_i = '0, r_user_i = '0;
    logic r_valid_i = 1'b0, r_ready_o, r_last_i = 1'b1;
    logic [DW-1:0] r_data_i = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    core2axi_mo #(
        .AXI4_ADDRESS_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IDW),
        .AXI4_USER_WIDTH(UW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_addr_i(data_addr_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
`ifdef CORE2AXI_MO_ERR_EN
        .data_err_o(data_err_o),
`endif
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
        .aw_id_o(aw_id_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
        .aw_lock_o(aw_lock_o), .aw_cache_o(aw_cache_o), .aw_prot_o(aw_prot_o),
        .aw_region_o(aw_region_o), .aw_qos_o(aw_qos_o), .aw_user_o(aw_user_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
        .w_last_o(w_last_o), .w_user_o(w_user_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
        .b_id_i(b_id_i), .b_user_i(b_user_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
        .ar_id_o(ar_id_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
        .ar_lock_o(ar_lock_o), .ar_cache_o(ar_cache_o), .ar_prot_o(ar_prot_o),
        .ar_region_o(ar_region_o), .ar_qos_o(ar_qos_o), .ar_user_o(ar_user_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
        .r_last_i(r_last_i), .r_id_i(r_id_i), .r_user_i(r_user_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] drain_exp [3];
        drain_exp[0] = 32'h0000_2000;
        drain_exp[1] = 32'h0000_1001;
        drain_exp[2] = 32'h0000_2002;

        // Reset state and constant sidebands
        @(negedge clk_i);
        chk("rst_gnt", 64'(data_gnt_o), 64'd0);
        chk("rst_rvalid", 64'(data_rvalid_o), 64'd0);
        chk("rst_valids", 64'({ar_valid_o, aw_valid_o, w_valid_o}), 64'd0);
        chk("rst_readys", 64'({b_ready_o, r_ready_o}), 64'd0);
        chk("rst_rdata", 64'(data_rdata_o), 64'd0);
        chk("const_sb", 64'({w_last_o, aw_size_o, ar_size_o, aw_len_o, ar_burst_o}), {53'd0, 1'b1, 3'b010, 3'b010, 8'd0, 2'b00});
        next_cycle();
        rst_ni = 1'b1;

        // Four back-to-back reads fill the tracker
        ar_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h100 + 32'(4 * i);
            @(negedge clk_i);
            chk($sformatf("rd%0d_arvalid", i), 64'(ar_valid_o), 64'd1);
            chk($sformatf("rd%0d_gnt", i), 64'(data_gnt_o), 64'd1);
            chk($sformatf("rd%0d_araddr", i), 64'(ar_addr_o), 64'(32'h100 + 32'(4 * i)));
            next_cycle();
        end
        data_addr_i = 32'h110;
        @(negedge clk_i);
        chk("rd4_stall_arvalid", 64'(ar_valid_o), 64'd0);
        chk("rd4_stall_gnt", 64'(data_gnt_o), 64'd0);
        chk("rd4_stall_rready", 64'(r_ready_o), 64'd1);
        next_cycle();
        @(negedge clk_i);
        chk("rd4_stall2_gnt", 64'(data_gnt_o), 64'd0);
        next_cycle();

        // First response pops while full: no same-cycle bypass of the 5th read
        r_valid_i = 1'b1; r_data_i = {32'hB0B0_0001, 32'hA0A0_0000};
        @(negedge clk_i);
        chk("pop0_rvalid", 64'(data_rvalid_o), 64'd1);
        chk("pop0_rdata", 64'(data_rdata_o), 64'h0000_0000_A0A0_0000);
        chk("pop0_gnt_nobypass", 64'(data_gnt_o), 64'd0);
        next_cycle();

        // Response and new AR in the same cycle
        r_data_i = {32'h2222_2222, 32'h1111_1111};
        @(negedge clk_i);
        chk("pushpop_rvalid", 64'(data_rvalid_o), 64'd1);
        chk("pushpop_rdata", 64'(data_rdata_o), 64'h0000_0000_2222_2222);
        chk("pushpop_gnt", 64'(data_gnt_o), 64'd1);
        next_cycle();

        // Drain the remaining three reads (lanes 0, 1, 0)
        data_req_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            r_data_i = {32'h0000_1000 + 32'(k), 32'h0000_2000 + 32'(k)};
            @(negedge clk_i);
            chk($sformatf("drain%0d_rvalid", k), 64'(data_rvalid_o), 64'd1);
            chk($sformatf("drain%0d_rdata", k), 64'(data_rdata_o), 64'(drain_exp[k]));
            next_cycle();
        end
        r_valid_i = 1'b0;
        @(negedge clk_i);
        chk("drained_rready", 64'(r_ready_o), 64'd0);
        next_cycle();

        // Write with W immediate and AW delayed three cycles
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h4;
        data_be_i = 4'b0011; data_wdata_i = 32'hDEAD_BEEF;
        aw_ready_i = 1'b0; w_ready_i = 1'b1;
        @(negedge clk_i);
        chk("wr_c0_wvalid", 64'(w_valid_o), 64'd1);
        chk("wr_c0_awvalid", 64'(aw_valid_o), 64'd1);
        chk("wr_c0_gnt", 64'(data_gnt_o), 64'd0);
        chk("wr_strb", 64'(w_strb_o), 64'h30);
        chk("wr_wdata", w_data_o, 64'hDEAD_BEEF_DEAD_BEEF);
        next_cycle();
        for (int c = 1; c < 3; c++) begin
            @(negedge clk_i);
            chk($sformatf("wr_c%0d_wvalid", c), 64'(w_valid_o), 64'd0);
            chk($sformatf("wr_c%0d_gnt", c), 64'(data_gnt_o), 64'd0);
            next_cycle();
        end
        aw_ready_i = 1'b1;
        @(negedge clk_i);
        chk("wr_c3_awvalid", 64'(aw_valid_o), 64'd1);
        chk("wr_c3_gnt", 64'(data_gnt_o), 64'd1);
        chk("wr_c3_awaddr", 64'(aw_addr_o), 64'h4);
        next_cycle();
        data_req_i = 1'b0; aw_ready_i = 1'b0;
        b_valid_i = 1'b1; b_resp_i = OKAY;
        @(negedge clk_i);
        chk("wr_bready", 64'(b_ready_o), 64'd1);
        chk("wr_rvalid", 64'(data_rvalid_o), 64'd1);
        chk("wr_rdata", 64'(data_rdata_o), 64'd0);
`ifdef CORE2AXI_MO_ERR_EN
        chk("wr_err_okay", 64'(data_err_o), 64'd0);
`endif
        next_cycle();
        b_valid_i = 1'b0;
        @(negedge clk_i);
        chk("wr_bready_done", 64'(b_ready_o), 64'd0);
        next_cycle();

        // Type switch: write waits for the outstanding read
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h8; ar_ready_i = 1'b1;
        @(negedge clk_i);
        chk("sw_rd_gnt", 64'(data_gnt_o), 64'd1);
        next_cycle();
        data_we_i = 1'b1; data_addr_i = 32'h0; data_be_i = 4'b1111; data_wdata_i = 32'hCAFE_F00D;
        aw_ready_i = 1'b1; w_ready_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            chk($sformatf("sw_blk%0d_aw_w", c), 64'({aw_valid_o, w_valid_o}), 64'd0);
            chk($sformatf("sw_blk%0d_gnt", c), 64'(data_gnt_o), 64'd0);
            next_cycle();
        end
        r_valid_i = 1'b1; r_data_i = {32'h5555_5555, 32'h4444_4444};
        @(negedge clk_i);
        chk("sw_r_rvalid", 64'(data_rvalid_o), 64'd1);
        chk("sw_r_rdata", 64'(data_rdata_o), 64'h0000_0000_4444_4444);
        chk("sw_r_awvalid", 64'(aw_valid_o), 64'd0);
        next_cycle();
        r_valid_i = 1'b0;
        @(negedge clk_i);
        chk("sw_wr_aw_w", 64'({aw_valid_o, w_valid_o}), 64'd3);
        chk("sw_wr_gnt", 64'(data_gnt_o), 64'd1);
        chk("sw_wr_strb", 64'(w_strb_o), 64'h0F);
        next_cycle();
        data_req_i = 1'b0;
        b_valid_i = 1'b1; b_resp_i = SLVERR;
        @(negedge clk_i);
        chk("sw_b_rvalid", 64'(data_rvalid_o), 64'd1);
`ifdef CORE2AXI_MO_ERR_EN
        chk("sw_b_err", 64'(data_err_o), 64'd1);
`endif
        next_cycle();
        b_valid_i = 1'b0; b_resp_i = OKAY;

        // Reset with two reads outstanding
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h20;
        next_cycle();
        data_addr_i = 32'h24;
        @(negedge clk_i);
        chk("pre_rst_gnt", 64'(data_gnt_o), 64'd1);
        next_cycle();
        data_req_i = 1'b0;
        next_cycle();
        rst_ni = 1'b0; r_valid_i = 1'b1; r_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk_i);
        chk("midrst_readys", 64'({r_ready_o, b_ready_o}), 64'd0);
        chk("midrst_rvalid_gnt", 64'({data_rvalid_o, data_gnt_o}), 64'd0);
        chk("midrst_valids", 64'({ar_valid_o, aw_valid_o, w_valid_o}), 64'd0);
        next_cycle();
        rst_ni = 1'b1; r_valid_i = 1'b0;
        data_req_i = 1'b1; data_addr_i = 32'h30;
        @(negedge clk_i);
        chk("postrst_gnt", 64'(data_gnt_o), 64'd1);
        next_cycle();
        data_req_i = 1'b0;
        r_valid_i = 1'b1; r_data_i = {32'h8888_0034, 32'h7777_0030};
        @(negedge clk_i);
        chk("postrst_rdata", 64'(data_rdata_o), 64'h0000_0000_7777_0030);
        next_cycle();
        r_valid_i = 1'b0;
        @(negedge clk_i);
        chk("postrst_empty", 64'(r_ready_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
